// File: rtl/testbus_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | testbus_arbiter_if : request/data/force inputs and grant/bus/LED out  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface testbus_arbiter_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0]   iv_REQ;
  logic [8*NUM_SRC-1:0] iv_TEST_DATA;
  logic                 i_FORCE_EN;
  logic [2:0]           iv_FORCE_SEL;
  logic [NUM_SRC-1:0]   ov_GRANT;
  logic [7:0]           ov_FPGA_TEST;
  logic                 o_LED;

  modport master (
    output iv_REQ, iv_TEST_DATA, i_FORCE_EN, iv_FORCE_SEL,
    input  ov_GRANT, ov_FPGA_TEST, o_LED
  );

  modport slave (
    input  iv_REQ, iv_TEST_DATA, i_FORCE_EN, iv_FORCE_SEL,
    output ov_GRANT, ov_FPGA_TEST, o_LED
  );
endinterface
`default_nettype wire

// File: rtl/testbus_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | testbus_arbiter : round-robin owner of the FPGA test bus and LED      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module testbus_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 1024,
  parameter int LED_TICK     = 200000
) (
  input  logic              i_CLK,
  input  logic              i_RESET,
  testbus_arbiter_if.slave  bus
);
  localparam int DW_W = $clog2(DWELL_CYCLES + 1);
  localparam int TK_W = (LED_TICK > 1) ? $clog2(LED_TICK) : 1;
  localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(DWELL_CYCLES);
  localparam logic [TK_W-1:0] TICK_LAST = TK_W'(LED_TICK - 1);
  localparam logic [3:0]      NSRC      = 4'(NUM_SRC);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [2:0]         owner_q, owner_d;
  logic [2:0]         rr_q, rr_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;
  logic [TK_W-1:0]    tick_q, tick_d;
  logic [3:0]         slot_q, slot_d;
  logic               force_q;
  logic [7:0]         bus_q, bus_d;
  logic               led_q, led_d;

  logic [NUM_SRC-1:0] w_cand, w_rot;
  logic [2:0]         w_off, w_pick, w_rr_next;
  logic [3:0]         w_sum;
  logic               w_found, w_owner_req, w_force_ok;
  logic [4:0]         w_led_lim;

  function automatic logic [NUM_SRC-1:0] onehot(input logic [2:0] idx);
    logic [NUM_SRC-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_SRC; i++) v[i] = (idx == 3'(i));
    return v;
  endfunction

  // Candidates exclude the current owner, so one scan from rr_q serves both
  // the idle pick and the "next after owner" handover.
  always_comb begin
    w_cand  = bus.iv_REQ & ~grant_q;
    w_rot   = NUM_SRC'({w_cand, w_cand} >> rr_q);
    w_found = 1'b0;
    w_off   = 3'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_off   = 3'(i);
      end
    end
    w_sum       = {1'b0, rr_q} + {1'b0, w_off};
    w_pick      = (w_sum >= NSRC) ? 3'(w_sum - NSRC) : w_sum[2:0];
    w_rr_next   = (({1'b0, w_pick} + 4'd1) == NSRC) ? 3'd0 : w_pick + 3'd1;
    w_owner_req = |(bus.iv_REQ & grant_q);
    w_force_ok  = ({1'b0, bus.iv_FORCE_SEL} < NSRC);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    dwell_d = dwell_q;
    if (bus.i_FORCE_EN) begin
      state_d = IDLE;
      dwell_d = '0;
      grant_d = w_force_ok ? onehot(bus.iv_FORCE_SEL) : '0;
    end else if (force_q) begin
      state_d = IDLE;
      dwell_d = '0;
      grant_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_found) begin
            state_d = GRANT;
            grant_d = onehot(w_pick);
            owner_d = w_pick;
            rr_d    = w_rr_next;
            dwell_d = '0;
          end
        end
        GRANT: begin
          dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + DW_W'(1);
          if (w_found && (!w_owner_req || dwell_q == DWELL_MAX)) begin
            grant_d = onehot(w_pick);
            owner_d = w_pick;
            rr_d    = w_rr_next;
            dwell_d = '0;
          end else if (!w_owner_req) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Restarting on any grant change makes every owner's pattern begin at pulse 1.
  always_comb begin
    tick_d = tick_q + TK_W'(1);
    slot_d = slot_q;
    if (grant_d != grant_q) begin
      tick_d = '0;
      slot_d = '0;
    end else if (tick_q == TICK_LAST) begin
      tick_d = '0;
      slot_d = slot_q + 4'd1;
    end
  end

  always_comb begin
    bus_d = 8'h00;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) bus_d = bus_d | bus.iv_TEST_DATA[8*i +: 8];
    end
    w_led_lim = {1'b0, owner_q, 1'b0} + 5'd2;
    led_d     = force_q ||
                (state_q == GRANT && !slot_q[0] && ({1'b0, slot_q} < w_led_lim));
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= 3'd0;
      rr_q    <= 3'd0;
      dwell_q <= '0;
      tick_q  <= '0;
      slot_q  <= 4'd0;
      force_q <= 1'b0;
      bus_q   <= 8'h00;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      dwell_q <= dwell_d;
      tick_q  <= tick_d;
      slot_q  <= slot_d;
      force_q <= bus.i_FORCE_EN;
      bus_q   <= bus_d;
      led_q   <= led_d;
    end
  end

  assign bus.ov_GRANT     = grant_q;
  assign bus.ov_FPGA_TEST = bus_q;
  assign bus.o_LED        = led_q;
endmodule
`default_nettype wire
